// File: rtl/div_clock_prog.sv
// -----------------------------------------------------------------------------
// div_clock_prog
//
// Multi-channel, run-time programmable clock divider. Each of the N_CH channels
// runs its own counter over a divisor D and produces a registered divided
// waveform (high for the first H cycles of each period) plus a one-cycle TICK
// at every period start. New divisor/high-time values are written to a shadow
// and only become active at a period boundary, so the waveform never glitches.
//
// Optional feature: define DIV_CLOCK_PHASE_EN to add PHASE_IN. The phase is
// captured on LOAD and gives the counter start value (PHASE mod D) on SYNC
// and on ENABLE 0->1.
//
// Parameters
//   N_CH        number of independent channels
//   W           counter / divisor / high-time width
//   DEFAULT_DIV divisor loaded at reset (high-time = DEFAULT_DIV/2)
//
// Ports
//   CLOCK_IN    system clock, rising edge
//   RESET_N     synchronous active-low reset
//   DIV_IN      per-channel divisor, channel i at [i*W +: W]
//   HIGH_IN     per-channel high-time, same packing
//   PHASE_IN    per-channel start phase (DIV_CLOCK_PHASE_EN only)
//   LOAD        per-channel load strobe
//   ENABLE      per-channel run enable
//   SYNC        global realign strobe
//   CLOCK_OUT   registered divided waveforms
//   TICK        registered one-cycle period-start pulses
//   PENDING     shadow captured but not yet active
// -----------------------------------------------------------------------------
module div_clock_prog #(
   parameter int N_CH        = 4,
   parameter int W           = 28,
   parameter int DEFAULT_DIV = 2
) (
   input  logic              CLOCK_IN,
   input  logic              RESET_N,
   input  logic [N_CH*W-1:0] DIV_IN,
   input  logic [N_CH*W-1:0] HIGH_IN,
`ifdef DIV_CLOCK_PHASE_EN
   input  logic [N_CH*W-1:0] PHASE_IN,
`endif
   input  logic [N_CH-1:0]   LOAD,
   input  logic [N_CH-1:0]   ENABLE,
   input  logic              SYNC,
   output logic [N_CH-1:0]   CLOCK_OUT,
   output logic [N_CH-1:0]   TICK,
   output logic [N_CH-1:0]   PENDING
);

   localparam logic [W-1:0] DEF_DIV  = W'(DEFAULT_DIV);
   localparam logic [W-1:0] DEF_HIGH = W'(DEFAULT_DIV / 2);

   // Divisors 0 and 1 cannot produce a period, so they run as 2.
   function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
      if (d < W'(2)) begin
         return W'(2);
      end
      return d;
   endfunction

`ifdef DIV_CLOCK_PHASE_EN
   // Start value is reduced into the range of the divisor being applied.
   function automatic logic [W-1:0] start_cnt(input logic [W-1:0] ph,
                                              input logic [W-1:0] d);
      return ph % clamp_div(d);
   endfunction
`endif

   // Per-channel state
   logic [N_CH-1:0][W-1:0] cnt_q,      cnt_d;
   logic [N_CH-1:0][W-1:0] div_act_q,  div_act_d;
   logic [N_CH-1:0][W-1:0] high_act_q, high_act_d;
   logic [N_CH-1:0][W-1:0] div_sh_q,   div_sh_d;
   logic [N_CH-1:0][W-1:0] high_sh_q,  high_sh_d;
`ifdef DIV_CLOCK_PHASE_EN
   logic [N_CH-1:0][W-1:0] phase_sh_q, phase_sh_d;
`endif
   logic [N_CH-1:0]        pend_q,     pend_d;
   logic [N_CH-1:0]        clk_out_q,  clk_out_d;
   logic [N_CH-1:0]        tick_q,     tick_d;

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         logic [W-1:0] d_cur;
         logic [W-1:0] div_in_i;
         logic [W-1:0] high_in_i;
         logic [W-1:0] src_div;
         logic [W-1:0] src_high;
         logic [W-1:0] start_val;
         logic         wrap;
         logic         apply;

         d_cur     = clamp_div(div_act_q[i]);
         div_in_i  = DIV_IN[i*W +: W];
         high_in_i = HIGH_IN[i*W +: W];

         wrap  = ENABLE[i] && (cnt_q[i] == d_cur - W'(1));
         // Boundaries where a new D/H may take effect without a runt period.
         apply = wrap || !ENABLE[i] || SYNC;

         // A LOAD coinciding with an apply bypasses the shadow.
         src_div  = LOAD[i] ? div_in_i  : div_sh_q[i];
         src_high = LOAD[i] ? high_in_i : high_sh_q[i];

`ifdef DIV_CLOCK_PHASE_EN
         phase_sh_d[i] = LOAD[i] ? PHASE_IN[i*W +: W] : phase_sh_q[i];
         start_val     = start_cnt(LOAD[i] ? PHASE_IN[i*W +: W] : phase_sh_q[i],
                                   src_div);
`else
         start_val     = '0;
`endif

         div_sh_d[i]   = LOAD[i] ? div_in_i  : div_sh_q[i];
         high_sh_d[i]  = LOAD[i] ? high_in_i : high_sh_q[i];
         div_act_d[i]  = apply ? src_div  : div_act_q[i];
         high_act_d[i] = apply ? src_high : high_act_q[i];

         if (apply) begin
            pend_d[i] = 1'b0;
         end else if (LOAD[i]) begin
            pend_d[i] = 1'b1;
         end else begin
            pend_d[i] = pend_q[i];
         end

         // While disabled the counter parks at its start value, so the first
         // enabled cycle begins a clean period (same as reset release).
         if (!ENABLE[i]) begin
            cnt_d[i] = start_val;
         end else if (SYNC) begin
            cnt_d[i] = start_val;
         end else if (wrap) begin
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + W'(1);
         end

         // Outputs are registered from the current count, one cycle behind it.
         clk_out_d[i] = ENABLE[i] && (cnt_q[i] < high_act_q[i]);
         tick_d[i]    = ENABLE[i] && (cnt_q[i] == '0);
      end
   end

   always_ff @(posedge CLOCK_IN) begin
      if (!RESET_N) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i]      <= '0;
            div_act_q[i]  <= DEF_DIV;
            high_act_q[i] <= DEF_HIGH;
            div_sh_q[i]   <= DEF_DIV;
            high_sh_q[i]  <= DEF_HIGH;
`ifdef DIV_CLOCK_PHASE_EN
            phase_sh_q[i] <= '0;
`endif
         end
         pend_q    <= '0;
         clk_out_q <= '0;
         tick_q    <= '0;
      end else begin
         cnt_q      <= cnt_d;
         div_act_q  <= div_act_d;
         high_act_q <= high_act_d;
         div_sh_q   <= div_sh_d;
         high_sh_q  <= high_sh_d;
`ifdef DIV_CLOCK_PHASE_EN
         phase_sh_q <= phase_sh_d;
`endif
         pend_q     <= pend_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
      end
   end

   assign CLOCK_OUT = clk_out_q;
   assign TICK      = tick_q;
   assign PENDING   = pend_q;

endmodule

// File: tb/tb_div_clock_prog.sv
// -----------------------------------------------------------------------------
// tb_div_clock_prog
//
// Directed bench for div_clock_prog with hand-computed waveform patterns.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the
// same point, i.e. they show the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_div_clock_prog;

   localparam int N_CH = 4;
   localparam int W    = 28;

   logic              clk;
   logic              rst_n;
   logic [N_CH*W-1:0] div_in;
   logic [N_CH*W-1:0] high_in;
`ifdef DIV_CLOCK_PHASE_EN
   logic [N_CH*W-1:0] phase_in;
`endif
   logic [N_CH-1:0]   load;
   logic [N_CH-1:0]   enable;
   logic              sync;
   logic [N_CH-1:0]   clock_out;
   logic [N_CH-1:0]   tick;
   logic [N_CH-1:0]   pending;

   int n_chk;
   int n_fail;

   div_clock_prog #(
      .N_CH        (N_CH),
      .W           (W),
      .DEFAULT_DIV (2)
   ) dut (
      .CLOCK_IN  (clk),
      .RESET_N   (rst_n),
      .DIV_IN    (div_in),
      .HIGH_IN   (high_in),
`ifdef DIV_CLOCK_PHASE_EN
      .PHASE_IN  (phase_in),
`endif
      .LOAD      (load),
      .ENABLE    (enable),
      .SYNC      (sync),
      .CLOCK_OUT (clock_out),
      .TICK      (tick),
      .PENDING   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Program a channel while it is disabled: the load is applied at once.
   task automatic prog(input int ch, input logic [W-1:0] dv, input logic [W-1:0] hi);
      enable[ch]          = 1'b0;
      div_in[ch*W +: W]   = dv;
      high_in[ch*W +: W]  = hi;
      load[ch]            = 1'b1;
      step();
      load[ch]            = 1'b0;
      check($sformatf("prog%0d_pend", ch), 32'(pending[ch]), 32'd0);
   endtask

   // Enable a channel and compare n cycles against MSB-first patterns.
   task automatic run_ch(input string tag, input int ch, input int n,
                         input logic [31:0] exp_clk, input logic [31:0] exp_tick);
      enable[ch] = 1'b1;
      for (int i = 0; i < n; i++) begin
         step();
         check($sformatf("%s_clk%0d", tag, i),  32'(clock_out[ch]), 32'(exp_clk[n-1-i]));
         check($sformatf("%s_tick%0d", tag, i), 32'(tick[ch]),      32'(exp_tick[n-1-i]));
      end
   endtask

   initial begin
      logic [0:17] mid_clk;
      logic [0:17] mid_tick;
      logic [0:17] mid_pend;
      logic [0:7]  s0_clk;
      logic [0:7]  s0_tick;
      logic [0:7]  s2_clk;
      logic [0:7]  s2_tick;

      n_chk   = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      div_in  = '0;
      high_in = '0;
`ifdef DIV_CLOCK_PHASE_EN
      phase_in = '0;
`endif
      load    = '0;
      enable  = '0;
      sync    = 1'b0;

      // Reset default: divide by 2 on every channel.
      step(); step(); step();
      check("rst_clk",  32'(clock_out), 32'd0);
      check("rst_tick", 32'(tick),      32'd0);
      check("rst_pend", 32'(pending),   32'd0);
      rst_n  = 1'b1;
      enable = '1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("def_clk%0d", i),  32'(clock_out), (i % 2 == 0) ? 32'hF : 32'h0);
         check($sformatf("def_tick%0d", i), 32'(tick),      (i % 2 == 0) ? 32'hF : 32'h0);
         check($sformatf("def_pend%0d", i), 32'(pending),   32'd0);
      end

      // Program ch0 DIV=5 HIGH=2 while idle.
      enable = '0;
      step();
      prog(0, 28'd5, 28'd2);
      run_ch("p5", 0, 10, 32'b1100011000, 32'b1000010000);

      // Mid-period change on ch1: 10/5 -> 4/1 loaded at cnt=3.
      enable   = '0;
      step();
      prog(1, 28'd10, 28'd5);
      mid_clk  = 18'b111110000010001000;
      mid_tick = 18'b100000000010001000;
      mid_pend = 18'b000111111000000000;
      enable[1] = 1'b1;
      for (int i = 0; i < 18; i++) begin
         if (i == 3) begin
            div_in[1*W +: W]  = 28'd4;
            high_in[1*W +: W] = 28'd1;
            load[1]           = 1'b1;
         end
         step();
         load[1] = 1'b0;
         check($sformatf("mid_clk%0d", i),  32'(clock_out[1]), 32'(mid_clk[i]));
         check($sformatf("mid_tick%0d", i), 32'(tick[1]),      32'(mid_tick[i]));
         check($sformatf("mid_pend%0d", i), 32'(pending[1]),   32'(mid_pend[i]));
      end

      // Clamp and high-time edge cases on ch2.
      enable = '0;
      step();
      prog(2, 28'd0, 28'd1);
      run_ch("d0", 2, 6, 32'b101010, 32'b101010);
      prog(2, 28'd6, 28'd0);
      run_ch("h0", 2, 12, 32'b000000000000, 32'b100000100000);
      prog(2, 28'd6, 28'd9);
      run_ch("h9", 2, 12, 32'b111111111111, 32'b100000100000);

      // SYNC realign of misaligned ch0 (DIV=3) and ch2 (DIV=7), with a
      // coincident LOAD of DIV=4 HIGH=2 on ch2.
      enable = '0;
      step();
      prog(0, 28'd3, 28'd1);
      prog(2, 28'd7, 28'd3);
      enable[0] = 1'b1;
      step(); step();
      enable[2] = 1'b1;
      step(); step(); step();
      div_in[2*W +: W]  = 28'd4;
      high_in[2*W +: W] = 28'd2;
      load[2] = 1'b1;
      sync    = 1'b1;
      step();
      load[2] = 1'b0;
      sync    = 1'b0;
      check("sync_pend", 32'(pending), 32'd0);
      s0_clk  = 8'b10010010;
      s0_tick = 8'b10010010;
      s2_clk  = 8'b11001100;
      s2_tick = 8'b10001000;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("sync0_clk%0d", i),  32'(clock_out[0]), 32'(s0_clk[i]));
         check($sformatf("sync0_tick%0d", i), 32'(tick[0]),      32'(s0_tick[i]));
         check($sformatf("sync2_clk%0d", i),  32'(clock_out[2]), 32'(s2_clk[i]));
         check($sformatf("sync2_tick%0d", i), 32'(tick[2]),      32'(s2_tick[i]));
      end

      // Reset while ch3 is mid-period with a pending load.
      enable = '0;
      step();
      prog(3, 28'd10, 28'd4);
      enable[3] = 1'b1;
      step(); step();
      div_in[3*W +: W]  = 28'd8;
      high_in[3*W +: W] = 28'd3;
      load[3] = 1'b1;
      step();
      load[3] = 1'b0;
      step(); step();
      check("r3_pend_before", 32'(pending[3]), 32'd1);
      rst_n = 1'b0;
      step();
      check("r3_clk",  32'(clock_out), 32'd0);
      check("r3_tick", 32'(tick),      32'd0);
      check("r3_pend", 32'(pending),   32'd0);
      rst_n = 1'b1;
      run_ch("r3_def", 3, 4, 32'b1010, 32'b1010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/div_clock_prog.md
Name: div_clock_prog

Overview:
Multi-channel, run-time programmable clock divider. Generates N_CH independent divided clock-enable waveforms from CLOCK_IN, each with its own divisor and high-time (duty). Divisor changes are glitch-free, applied only at period boundaries. Used to derive LED, ADC-sample and HSMC strobe timebases from the 50 MHz board clock. A single-cycle TICK per channel marks each period start. A global SYNC realigns all channels.

Parameters:
N_CH, 4, number of independent output channels
W, 28, counter / divisor / high-time width in bits
DEFAULT_DIV, 2, divisor loaded into every channel at reset (must be >= 2)

Ports:
CLOCK_IN  input  1  system clock; all logic on its rising edge
RESET_N  input  1  synchronous, active-low reset
DIV_IN  input  N_CH*W  per-channel divisor; channel i at bits [i*W +: W]
HIGH_IN  input  N_CH*W  per-channel high-time in CLOCK_IN cycles; same packing
LOAD  input  N_CH  per-channel load strobe; captures DIV_IN/HIGH_IN slice
ENABLE  input  N_CH  per-channel run enable
SYNC  input  1  global realign strobe
CLOCK_OUT  output  N_CH  divided waveforms, registered
TICK  output  N_CH  one-cycle pulse coincident with each CLOCK_OUT period start, registered
PENDING  output  N_CH  shadow value captured but not yet active

Behaviour:
- Reset (RESET_N=0 at clock edge): cnt=0; active div=DEFAULT_DIV; active high=DEFAULT_DIV/2; shadow=active; CLOCK_OUT=0; TICK=0; PENDING=0. Reset overrides all other inputs.
- Per-channel counter cnt counts 0..D-1, then wraps to 0. D = active div clamped: values 0 and 1 are treated as 2. Arithmetic is unsigned W-bit. No overflow, since cnt < D <= 2^W-1.
- Outputs are registered from the current cnt:
  - CLOCK_OUT <= (cnt < H)
  - TICK <= (cnt == 0)
  - Output lags cnt by 1 cycle.
  - Period = D cycles; high for min(H,D) cycles.
  - H=0 gives CLOCK_OUT constantly 0; H>=D gives constantly 1. TICK still pulses once per period in both cases.
- First output after reset release with ENABLE=1: cycle 0 has cnt=0; cycle 1 has CLOCK_OUT=1 and TICK=1.
- LOAD[i]:
  - Captures the slice into shadow and sets PENDING[i]=1.
  - A later LOAD before application overwrites the shadow (last write wins).
- Shadow becomes active (PENDING cleared) at the first of these:
  - wrap cycle, i.e. cnt==D-1 and ENABLE=1
  - any cycle with ENABLE[i]=0
  - SYNC=1
- LOAD coinciding with an apply event: the incoming DIV_IN/HIGH_IN bypasses the shadow and becomes active immediately. PENDING stays 0.
- ENABLE[i]=0: cnt held at 0; CLOCK_OUT and TICK go 0 on the next edge.
- ENABLE 0->1: behaves like reset release (period starts cleanly, no runt pulse).
- SYNC=1: every enabled channel sets cnt<=0 (or the phase offset, see Optional Feature). Pending loads are applied. SYNC has priority over the normal increment/wrap. The next cycle shows the period start on all enabled channels simultaneously.
- Glitch-free rule: an active D or H never changes mid-period except via SYNC, ENABLE low or reset.
- Channels are fully independent except for the shared SYNC.

Optional Feature:
Macro DIV_CLOCK_PHASE_EN.
- When defined:
  - Adds input PHASE_IN (N_CH*W) and its shadow, both captured on LOAD.
  - On SYNC or ENABLE 0->1, cnt starts at (PHASE mod D) instead of 0.
  - TICK then first fires when cnt reaches 0.
  - Allows fixed inter-channel phase offsets.
- When undefined: no PHASE_IN port; start value is always 0. Behaviour is exactly as above.

Test Plan:
- Reset default: RESET_N low 3 cycles, then high, ENABLE=all 1, DEFAULT_DIV=2 -> every CLOCK_OUT toggles 1,0,1,0 starting cycle 1; TICK high every 2nd cycle; PENDING=0.
- Program: ch0 LOAD DIV=5 HIGH=2 while idle (ENABLE=0), then enable -> CLOCK_OUT pattern 1,1,0,0,0 repeating; TICK on each first 1.
- Mid-period change: ch1 running DIV=10 HIGH=5, LOAD DIV=4 HIGH=1 at cnt=3 -> PENDING=1 until cnt=9; current period completes 10 cycles; next periods 1,0,0,0; PENDING clears at wrap.
- Clamp/edge: DIV=0 HIGH=1 -> period 2 (1,0); DIV=6 HIGH=0 -> CLOCK_OUT stuck 0, TICK every 6; DIV=6 HIGH=9 -> CLOCK_OUT stuck 1, TICK every 6.
- SYNC realign: ch0 DIV=3, ch2 DIV=7, free-running misaligned; pulse SYNC -> next cycle both TICK=1 and CLOCK_OUT=1 together. Same cycle as a LOAD on ch2 DIV=4 -> DIV=4 used immediately.
- Reset mid-operation: assert RESET_N=0 while ch3 at cnt=5 with PENDING=1 -> next edge all outputs 0, PENDING=0, divisor back to DEFAULT_DIV.
